// File: rtl/ceas_pkg.sv
// Shared types and limits for the ceas alarm bank.
package ceas_pkg;

  localparam int ORE_W   = 5;
  localparam int MIN_W   = 6;
  localparam int ORE_MAX = 23;
  localparam int MIN_MAX = 59;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZED  = 2'd3
  } alarm_state_t;

  function automatic logic time_ok(input logic [ORE_W-1:0] h, input logic [MIN_W-1:0] m);
    return (h <= ORE_W'(ORE_MAX)) && (m <= MIN_W'(MIN_MAX));
  endfunction

endpackage

// File: rtl/ceas_alarm_channel.sv
// One alarm channel: stored time, rising-edge match detect and ring/snooze state machine.
// Snooze support is built only when CEAS_ALARM_SNOOZE_EN is defined.
//
// state    | meaning
// DISARMED | channel ignores the live time
// ARMED    | waiting for the live time to reach the stored time
// RINGING  | alarm active, counting minutes towards auto-stop
// SNOOZED  | alarm paused, counting snooze minutes down
module ceas_alarm_channel
  import ceas_pkg::*;
#(
  parameter int RING_MINUTES = 5,
  parameter int SNOOZE_MIN   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ORE_W-1:0] ore_counter,
  input  logic [MIN_W-1:0] minute_counter,
  input  logic             min_tick,
  input  logic             wr,
  input  logic             wr_en,
  input  logic [ORE_W-1:0] wr_ore,
  input  logic [MIN_W-1:0] wr_min,
  input  logic             stop,
  input  logic             snooze,
  output logic             ringing,
  output logic             active
);

  localparam int RW = $clog2(RING_MINUTES + 1);

  alarm_state_t     state, state_nxt;
  logic [ORE_W-1:0] ore_al;
  logic [MIN_W-1:0] min_al;
  logic             match, match_prev;
  logic [RW-1:0]    ring_cnt, ring_nxt;
`ifdef CEAS_ALARM_SNOOZE_EN
  logic [3:0]       snz_cnt, snz_nxt;
`else
  localparam int unused_snooze_min = SNOOZE_MIN;
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  assign match = (ore_counter == ore_al) && (minute_counter == min_al);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_DISARMED;
      ore_al     <= '0;
      min_al     <= '0;
      match_prev <= 1'b0;
      ring_cnt   <= '0;
`ifdef CEAS_ALARM_SNOOZE_EN
      snz_cnt    <= '0;
`endif
    end else begin
      state      <= state_nxt;
      ring_cnt   <= ring_nxt;
`ifdef CEAS_ALARM_SNOOZE_EN
      snz_cnt    <= snz_nxt;
`endif
      // a fresh load counts as "already matching" so loading the current time never fires
      match_prev <= wr ? 1'b1 : match;
      if (wr) begin
        ore_al <= wr_ore;
        min_al <= wr_min;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ring_nxt  = ring_cnt;
`ifdef CEAS_ALARM_SNOOZE_EN
    snz_nxt   = snz_cnt;
`endif
    if (wr) begin
      state_nxt = wr_en ? ST_ARMED : ST_DISARMED;
      ring_nxt  = '0;
`ifdef CEAS_ALARM_SNOOZE_EN
      snz_nxt   = '0;
`endif
    end else if (stop && (state == ST_RINGING || state == ST_SNOOZED)) begin
      state_nxt = ST_ARMED;
      ring_nxt  = '0;
`ifdef CEAS_ALARM_SNOOZE_EN
      snz_nxt   = '0;
    end else if (snooze && state == ST_RINGING) begin
      state_nxt = ST_SNOOZED;
      ring_nxt  = '0;
      snz_nxt   = 4'(SNOOZE_MIN);
`endif
    end else begin
      case (state)
        ST_ARMED: begin
          if (match && !match_prev) begin
            state_nxt = ST_RINGING;
            ring_nxt  = '0;
          end
        end
        ST_RINGING: begin
          if (min_tick) begin
            if (ring_cnt == RW'(RING_MINUTES - 1)) begin
              state_nxt = ST_ARMED;
              ring_nxt  = '0;
            end else begin
              ring_nxt = ring_cnt + RW'(1);
            end
          end
        end
        ST_SNOOZED: begin
`ifdef CEAS_ALARM_SNOOZE_EN
          if (min_tick) begin
            if (snz_cnt == 4'd1) begin
              state_nxt = ST_RINGING;
              ring_nxt  = '0;
              snz_nxt   = '0;
            end else begin
              snz_nxt = snz_cnt - 4'd1;
            end
          end
`else
          state_nxt = ST_ARMED;
`endif
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    ringing = (state == ST_RINGING);
    active  = (state != ST_DISARMED);
  end

endmodule

// File: rtl/ceas_alarm_bank.sv
// N-channel alarm bank: load validation/decode, per-channel alarms, led blink divider.
// Snooze is built only when CEAS_ALARM_SNOOZE_EN is defined.
module ceas_alarm_bank
  import ceas_pkg::*;
#(
  parameter int N_ALARMS     = 4,
  parameter int RING_MINUTES = 5,
  parameter int SNOOZE_MIN   = 5,
  parameter int BLINK_DIV    = 25_000_000,
  localparam int IW          = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ORE_W-1:0]    ore_counter,
  input  logic [MIN_W-1:0]    minute_counter,
  input  logic                min_tick,
  input  logic                load,
  input  logic [IW-1:0]       load_idx,
  input  logic                load_en,
  input  logic [ORE_W-1:0]    ore_setare,
  input  logic [MIN_W-1:0]    minute_setare,
  input  logic                stop,
  input  logic                snooze,
  output logic [N_ALARMS-1:0] ringing,
  output logic                load_err,
  output logic                led,
  output logic                led2
);

  localparam int DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic                load_ok;
  logic [N_ALARMS-1:0] wr;
  logic [N_ALARMS-1:0] active;
  logic [DW-1:0]       div_cnt;

  assign load_ok = time_ok(ore_setare, minute_setare) && (int'(load_idx) < N_ALARMS);

  for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
    assign wr[i] = load && load_ok && (load_idx == IW'(i));

    ceas_alarm_channel #(
      .RING_MINUTES(RING_MINUTES),
      .SNOOZE_MIN  (SNOOZE_MIN)
    ) u_ch (
      .clock         (clock),
      .reset         (reset),
      .ore_counter   (ore_counter),
      .minute_counter(minute_counter),
      .min_tick      (min_tick),
      .wr            (wr[i]),
      .wr_en         (load_en),
      .wr_ore        (ore_setare),
      .wr_min        (minute_setare),
      .stop          (stop),
      .snooze        (snooze),
      .ringing       (ringing[i]),
      .active        (active[i])
    );
  end

  assign led2 = |active;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load && !load_ok;
    end
  end

  // divider is held at zero whenever nothing rings so every ring starts with a full dark phase
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      led     <= 1'b0;
    end else if (!(|ringing)) begin
      div_cnt <= '0;
      led     <= 1'b0;
    end else if (div_cnt == DW'(BLINK_DIV - 1)) begin
      div_cnt <= '0;
      led     <= ~led;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: tb/tb_ceas_alarm_bank.sv
// Scoreboard bench for ceas_alarm_bank: reference model pushes expected outputs, monitor compares.
module tb_ceas_alarm_bank;

  localparam int N  = 3;
  localparam int RM = 5;
  localparam int SM = 5;
  localparam int BD = 4;
  localparam int IW = 2;
`ifdef CEAS_ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [4:0]    ore_counter = '0;
  logic [5:0]    minute_counter = '0;
  logic          min_tick = 1'b0;
  logic          load = 1'b0;
  logic [IW-1:0] load_idx = '0;
  logic          load_en = 1'b0;
  logic [4:0]    ore_setare = '0;
  logic [5:0]    minute_setare = '0;
  logic          stop = 1'b0;
  logic          snooze = 1'b0;
  logic [N-1:0]  ringing;
  logic          load_err;
  logic          led;
  logic          led2;

  always #5 clock = ~clock;

  ceas_alarm_bank #(
    .N_ALARMS(N), .RING_MINUTES(RM), .SNOOZE_MIN(SM), .BLINK_DIV(BD)
  ) dut (
    .clock(clock), .reset(reset), .ore_counter(ore_counter), .minute_counter(minute_counter),
    .min_tick(min_tick), .load(load), .load_idx(load_idx), .load_en(load_en),
    .ore_setare(ore_setare), .minute_setare(minute_setare), .stop(stop), .snooze(snooze),
    .ringing(ringing), .load_err(load_err), .led(led), .led2(led2)
  );

  typedef struct packed {
    logic [N-1:0] ring;
    logic         led;
    logic         led2;
    logic         err;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // model: 0 off, 1 waiting, 2 ringing, 3 snoozed; minutes left instead of up-counters
  int al_h[N], al_m[N], mode[N], ring_left[N], snz_left[N];
  bit was_eq[N];
  int ring_cycles;
  bit err_m;
  int cur_h = 0, cur_m = 0;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.ring = '0;
    e.led2 = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (mode[c] == 2) e.ring[c] = 1'b1;
      if (mode[c] != 0) e.led2 = 1'b1;
    end
    e.led = ((ring_cycles / BD) % 2) == 1;
    e.err = err_m;
    return e;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      al_h[c] = 0; al_m[c] = 0; mode[c] = 0; ring_left[c] = 0; snz_left[c] = 0; was_eq[c] = 0;
    end
    ring_cycles = 0;
    err_m = 0;
  endfunction

  function automatic void model_step();
    bit any_ring = 0;
    bit valid;
    bit eq;
    for (int c = 0; c < N; c++) if (mode[c] == 2) any_ring = 1;
    ring_cycles = any_ring ? ring_cycles + 1 : 0;
    valid = (int'(ore_setare) <= 23) && (int'(minute_setare) <= 59) && (int'(load_idx) < N);
    err_m = load && !valid;
    for (int c = 0; c < N; c++) begin
      eq = (int'(ore_counter) == al_h[c]) && (int'(minute_counter) == al_m[c]);
      if (load && valid && int'(load_idx) == c) begin
        al_h[c] = int'(ore_setare);
        al_m[c] = int'(minute_setare);
        mode[c] = load_en ? 1 : 0;
        was_eq[c] = 1;
        continue;
      end
      if (stop && mode[c] >= 2) mode[c] = 1;
      else if (SNZ && snooze && mode[c] == 2) begin
        mode[c] = 3; snz_left[c] = SM;
      end else if (mode[c] == 1 && eq && !was_eq[c]) begin
        mode[c] = 2; ring_left[c] = RM;
      end else if (mode[c] == 2 && min_tick) begin
        ring_left[c]--;
        if (ring_left[c] == 0) mode[c] = 1;
      end else if (mode[c] == 3 && min_tick) begin
        snz_left[c]--;
        if (snz_left[c] == 0) begin
          mode[c] = 2; ring_left[c] = RM;
        end
      end
      was_eq[c] = eq;
    end
  endfunction

  initial model_reset();

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      model_reset();
      q.delete();
      q.push_back(model_out());
    end else begin
      model_step();
      q.push_back(model_out());
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ringing", int'(ringing), int'(e.ring));
      chk("led", int'(led), int'(e.led));
      chk("led2", int'(led2), int'(e.led2));
      chk("load_err", int'(load_err), int'(e.err));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_time(input int h, input int m);
    cur_h = h; cur_m = m;
    ore_counter = 5'(h); minute_counter = 6'(m);
    idle(1);
  endtask

  task automatic adv_min();
    cur_m++;
    if (cur_m == 60) begin
      cur_m = 0;
      cur_h = (cur_h + 1) % 24;
    end
    ore_counter = 5'(cur_h); minute_counter = 6'(cur_m);
    min_tick = 1'b1;
    idle(1);
    min_tick = 1'b0;
    idle(1);
  endtask

  task automatic do_load(input int idx, input int h, input int m, input bit en);
    load = 1'b1; load_idx = IW'(idx); ore_setare = 5'(h); minute_setare = 6'(m); load_en = en;
    idle(1);
    load = 1'b0;
  endtask

  task automatic pulse(input bit s, input bit z);
    stop = s; snooze = z;
    idle(1);
    stop = 1'b0; snooze = 1'b0;
  endtask

  initial begin
    int r;
    idle(3);
    reset = 1'b1;
    idle(2);
    // 1: basic fire, blink, led2
    set_time(7, 28);
    do_load(0, 7, 30, 1'b1);
    adv_min();
    adv_min();
    idle(12);
    // 2: auto-stop after RM minutes, fires again next time 07:30 appears
    repeat (RM) adv_min();
    idle(3);
    set_time(7, 29);
    adv_min();
    idle(3);
    // 3: snooze, then snooze+stop together
    pulse(1'b0, 1'b1);
    repeat (SM) adv_min();
    idle(3);
    pulse(1'b1, 1'b1);
    idle(3);
    // 4: rejected loads
    do_load(1, 24, 0, 1'b1);
    do_load(1, 0, 60, 1'b1);
    do_load(3, 1, 1, 1'b1);
    idle(2);
    // 5: load equal to current time, then two channels on one minute
    set_time(12, 0);
    do_load(1, 12, 0, 1'b1);
    idle(5);
    set_time(7, 58);
    do_load(1, 8, 0, 1'b1);
    do_load(2, 8, 0, 1'b1);
    adv_min();
    adv_min();
    idle(3);
    pulse(1'b1, 1'b0);
    idle(3);
    // 6: async reset while ringing
    set_time(7, 59);
    adv_min();
    idle(6);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("rst_ringing", int'(ringing), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_led2", int'(led2), 0);
    chk("rst_load_err", int'(load_err), 0);
    idle(3);
    reset = 1'b1;
    set_time(7, 59);
    adv_min();
    idle(4);
    // random traffic around the current time
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        if ($urandom_range(0, 5) == 0)
          do_load($urandom_range(0, 3), $urandom_range(20, 31), $urandom_range(50, 63), 1'($urandom));
        else
          do_load($urandom_range(0, N - 1), cur_h, (cur_m + $urandom_range(0, 2)) % 60,
                  $urandom_range(0, 4) != 0);
      end else if (r < 9) pulse(1'b1, 1'b0);
      else if (r < 14) pulse(1'b0, 1'b1);
      else if (r < 15) pulse(1'b1, 1'b1);
      else if (r < 45) adv_min();
      else if (r < 46) set_time($urandom_range(0, 23), $urandom_range(0, 59));
      else idle(1);
    end
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
